// File: rtl/ps2_key_event_pkg.sv
// Shared constants and FSM encoding for the PS/2 key event stage.
package ps2_key_event_pkg;

  localparam logic [7:0] BRK_CODE_DEFAULT = 8'hF0;
  localparam logic [7:0] ASCII_UNKNOWN    = 8'h23;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_BS         = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_key_event.sv
// Pops bytes from the upstream FWFT ASCII FIFO, folds break prefixes into releases,
// optionally suppresses typematic repeats and emits key events on a valid/ready stream.
//
// state  | meaning
// IDLE   | wait for FIFO not empty, latch head byte
// POP    | pop strobe high, classify latched byte
// SETTLE | let upstream empty flag update after the pop
// OUT    | present event until consumer accepts it
module ps2_key_event
  import ps2_key_event_pkg::*;
#(
  parameter bit         SUPPRESS_REPEAT = 1'b1,
  parameter bit         EMIT_BREAK      = 1'b0,
  parameter logic [7:0] BRK_CODE        = BRK_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_status,
  input  logic [31:0] fifo_data,
  output logic        fifo_rd,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [7:0]  key_data,
  output logic        key_brk,
  output logic [7:0]  drop_cnt
);

  state_t     state;
  logic [7:0] byte_q;
  logic [7:0] held;
  logic       held_vld;
  logic       brk_pend;
  logic       ev_pend;
  logic       ev_brk;

  // The full flag and upper data bits are deliberately not acted on.
  logic unused_bits;
  assign unused_bits = ^{fifo_status[31:1], fifo_data[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fifo_rd   <= 1'b0;
      key_valid <= 1'b0;
      key_data  <= 8'h00;
      key_brk   <= 1'b0;
      drop_cnt  <= 8'h00;
      byte_q    <= 8'h00;
      held      <= 8'h00;
      held_vld  <= 1'b0;
      brk_pend  <= 1'b0;
      ev_pend   <= 1'b0;
      ev_brk    <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_status[0]) begin
            byte_q  <= fifo_data[7:0];
            fifo_rd <= 1'b1;
            state   <= ST_POP;
          end
        end

        ST_POP: begin
          ev_pend <= 1'b0;
          // A pending break consumes the next byte, even another break code.
          if (brk_pend) begin
            brk_pend <= 1'b0;
            if (held_vld && held == byte_q) held_vld <= 1'b0;
            if (EMIT_BREAK) begin
              ev_pend <= 1'b1;
              ev_brk  <= 1'b1;
            end
          end else if (byte_q == BRK_CODE) begin
            brk_pend <= 1'b1;
          end else if (SUPPRESS_REPEAT && held_vld && held == byte_q) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            held     <= byte_q;
            held_vld <= 1'b1;
            ev_pend  <= 1'b1;
            ev_brk   <= 1'b0;
          end
          state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (ev_pend) begin
            key_valid <= 1'b1;
            key_data  <= byte_q;
            key_brk   <= ev_brk;
            state     <= ST_OUT;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_OUT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench: three instances (default, EMIT_BREAK=1, SUPPRESS_REPEAT=0), each fed by its own FWFT FIFO model.
module tb_ps2_key_event;

  logic        clk;
  logic        rst;
  logic        key_ready;
  logic [31:0] st0, st1, st2;
  logic [31:0] dt0, dt1, dt2;
  logic        fifo_rd0, fifo_rd1, fifo_rd2;
  logic        key_valid0, key_valid1, key_valid2;
  logic [7:0]  key_data0, key_data1, key_data2;
  logic        key_brk0, key_brk1, key_brk2;
  logic [7:0]  drop0, drop1, drop2;

  logic [7:0]  q0[$], q1[$], q2[$];
  logic [8:0]  ev0[$], ev1[$], ev2[$];
  int          rd_cnt0;
  int          total;
  int          bad;

  ps2_key_event dut0 (
    .clk(clk), .rst(rst), .fifo_status(st0), .fifo_data(dt0), .fifo_rd(fifo_rd0),
    .key_valid(key_valid0), .key_ready(key_ready), .key_data(key_data0),
    .key_brk(key_brk0), .drop_cnt(drop0)
  );

  ps2_key_event #(.EMIT_BREAK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fifo_status(st1), .fifo_data(dt1), .fifo_rd(fifo_rd1),
    .key_valid(key_valid1), .key_ready(key_ready), .key_data(key_data1),
    .key_brk(key_brk1), .drop_cnt(drop1)
  );

  ps2_key_event #(.SUPPRESS_REPEAT(1'b0)) dut2 (
    .clk(clk), .rst(rst), .fifo_status(st2), .fifo_data(dt2), .fifo_rd(fifo_rd2),
    .key_valid(key_valid2), .key_ready(key_ready), .key_data(key_data2),
    .key_brk(key_brk2), .drop_cnt(drop2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    st0 = {30'd0, q0.size() >= 16, q0.size() == 0};
    st1 = {30'd0, q1.size() >= 16, q1.size() == 0};
    st2 = {30'd0, q2.size() >= 16, q2.size() == 0};
    dt0 = (q0.size() > 0) ? {24'd0, q0[0]} : 32'd0;
    dt1 = (q1.size() > 0) ? {24'd0, q1[0]} : 32'd0;
    dt2 = (q2.size() > 0) ? {24'd0, q2[0]} : 32'd0;
  endtask

  task automatic push(input logic [7:0] b);
    q0.push_back(b);
    q1.push_back(b);
    q2.push_back(b);
    refresh();
  endtask

  // Samples pre-edge strobes/handshakes, advances one clock, then applies pops.
  task automatic tick();
    logic p0, p1, p2;
    p0 = fifo_rd0;
    p1 = fifo_rd1;
    p2 = fifo_rd2;
    if (key_valid0 && key_ready && !rst) ev0.push_back({key_brk0, key_data0});
    if (key_valid1 && key_ready && !rst) ev1.push_back({key_brk1, key_data1});
    if (key_valid2 && key_ready && !rst) ev2.push_back({key_brk2, key_data2});
    if (p0) rd_cnt0++;
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) q0.delete(0);
    if (p1 && q1.size() > 0) q1.delete(0);
    if (p2 && q2.size() > 0) q2.delete(0);
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    ev0.delete();
    ev1.delete();
    ev2.delete();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rd_cnt0 = 0;
    rst = 1'b1;
    key_ready = 1'b1;
    refresh();
    @(posedge clk);
    #1;
    run(2);
    check("rst_fifo_rd", fifo_rd0, 0);
    check("rst_key_valid", key_valid0, 0);
    check("rst_key_data", key_data0, 0);
    check("rst_key_brk", key_brk0, 0);
    check("rst_drop_cnt", drop0, 0);
    rst = 1'b0;
    run(2);

    // Single byte: pop strobe one cycle after empty falls, valid three cycles after.
    rd_cnt0 = 0;
    clear_logs();
    push(8'h41);
    tick();
    check("lat_rd_n1", fifo_rd0, 1);
    check("lat_valid_n1", key_valid0, 0);
    tick();
    check("lat_rd_n2", fifo_rd0, 0);
    check("lat_valid_n2", key_valid0, 0);
    tick();
    check("lat_valid_n3", key_valid0, 1);
    check("lat_data", key_data0, 8'h41);
    check("lat_brk", key_brk0, 0);
    run(6);
    check("lat_rd_pulses", rd_cnt0, 1);
    check("lat_events", ev0.size(), 1);
    check("lat_valid_after", key_valid0, 0);

    // Make / break / make-again handling.
    clear_logs();
    push(8'hF0);
    push(8'h41);
    run(16);
    check("brk_d0_events", ev0.size(), 0);
    check("brk_d1_events", ev1.size(), 1);
    check("brk_d1_ev0", ev1[0], {1'b1, 8'h41});
    clear_logs();
    push(8'h41);
    push(8'hF0);
    push(8'h41);
    run(20);
    check("mbm_d0_events", ev0.size(), 1);
    check("mbm_d0_ev0", ev0[0], {1'b0, 8'h41});
    check("mbm_d1_events", ev1.size(), 2);
    check("mbm_d1_ev0", ev1[0], {1'b0, 8'h41});
    check("mbm_d1_ev1", ev1[1], {1'b1, 8'h41});
    check("mbm_d2_events", ev2.size(), 1);

    // Typematic repeats: 41 x5, F0 41, 41.
    clear_logs();
    for (int i = 0; i < 5; i++) push(8'h41);
    push(8'hF0);
    push(8'h41);
    push(8'h41);
    run(50);
    check("rep_d0_events", ev0.size(), 2);
    check("rep_d0_ev0", ev0[0], {1'b0, 8'h41});
    check("rep_d0_ev1", ev0[1], {1'b0, 8'h41});
    check("rep_d0_drop", drop0, 4);
    check("rep_d2_events", ev2.size(), 6);
    check("rep_d2_drop", drop2, 0);
    check("rep_d1_events", ev1.size(), 3);

    // Back-pressure: three bytes queued while the consumer stalls.
    clear_logs();
    rd_cnt0 = 0;
    key_ready = 1'b0;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (key_valid0) begin
        check("bp_data_stable", key_data0, 8'h31);
        check("bp_no_pop", fifo_rd0, 0);
      end
    end
    check("bp_valid_held", key_valid0, 1);
    check("bp_pops_during_stall", rd_cnt0, 1);
    key_ready = 1'b1;
    run(20);
    check("bp_events", ev0.size(), 3);
    check("bp_ev0", ev0[0], {1'b0, 8'h31});
    check("bp_ev1", ev0[1], {1'b0, 8'h32});
    check("bp_ev2", ev0[2], {1'b0, 8'h33});

    // Reset in OUT, in POP, and with a break pending.
    clear_logs();
    key_ready = 1'b0;
    push(8'h51);
    run(4);
    check("rso_valid_before", key_valid0, 1);
    rst = 1'b1;
    tick();
    check("rso_valid", key_valid0, 0);
    check("rso_fifo_rd", fifo_rd0, 0);
    check("rso_drop", drop0, 0);
    rst = 1'b0;
    push(8'h52);
    tick();
    check("rsp_rd_before", fifo_rd0, 1);
    rst = 1'b1;
    tick();
    check("rsp_fifo_rd", fifo_rd0, 0);
    check("rsp_valid", key_valid0, 0);
    rst = 1'b0;
    key_ready = 1'b1;
    run(4);
    check("rsp_no_events", ev0.size(), 0);
    push(8'hF0);
    run(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(8'h42);
    run(10);
    check("rsb_events", ev0.size(), 1);
    check("rsb_ev0", ev0[0], {1'b0, 8'h42});

    // Saturating drop counter.
    clear_logs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) push(8'h31);
    run(1220);
    check("sat_drop", drop0, 8'hFF);
    check("sat_events", ev0.size(), 1);
    check("sat_ev0", ev0[0], {1'b0, 8'h31});
    check("sat_d2_events", ev2.size(), 300);
    check("sat_fifo_empty", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
